idct_pattern_gen: RTL and testbench

IDCT_PATTERN_GEN -- requirements
Module: idct_pattern_gen

---
 rtl/idct_pkg.sv | 54 +++++
 rtl/idct_pgen_lfsr.sv | 52 +++++
 rtl/idct_pattern_gen.sv | 202 ++++++++++++++++++++
 tb/tb_idct_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// ---------------------------------------------------------------------------
// idct_pkg
//
// Shared definitions for the IDCT test-pattern generator:
//   - pgen_mode_e  : pattern selector encoding as seen on the 'mode' port
//   - pgen_state_e : control FSM states of idct_pattern_gen
//   - LFSR_TAPS_*  : Fibonacci feedback masks for maximal-length LFSRs of
//                    the supported sample widths (8, 12, 16, 24, 32 bits)
//   - lfsrTaps()   : picks the feedback mask for a given sample width
//
// A set bit n in a tap mask means state bit n feeds the XOR that produces
// the next bit shifted into position 0.
// ---------------------------------------------------------------------------
package idct_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'b00,
        MODE_CONST   = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_IMPULSE = 2'b11
    } pgen_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } pgen_state_e;

    // Primitive polynomials, expressed as tap masks on state bits
    //   8 : x^8  + x^6  + x^5  + x^4 + 1
    //  12 : x^12 + x^6  + x^4  + x^1 + 1
    //  16 : x^16 + x^15 + x^13 + x^4 + 1
    //  24 : x^24 + x^23 + x^22 + x^17 + 1
    //  32 : x^32 + x^22 + x^2  + x^1 + 1
    localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] LFSR_TAPS_12 = 32'h0000_0829;
    localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
    localparam logic [31:0] LFSR_TAPS_24 = 32'h00E1_0000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // Widths outside the supported set get no taps; such an LFSR would just
    // shift in zeros, so only the listed widths give a usable sequence.
    function automatic logic [31:0] lfsrTaps(input int width);
        case (width)
            8:       return LFSR_TAPS_8;
            12:      return LFSR_TAPS_12;
            16:      return LFSR_TAPS_16;
            24:      return LFSR_TAPS_24;
            32:      return LFSR_TAPS_32;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/idct_pgen_lfsr.sv
// ---------------------------------------------------------------------------
// idct_pgen_lfsr
//
// Fibonacci maximal-length LFSR used by the pattern generator's LFSR mode.
// Only instantiated when IDCT_PGEN_LFSR_EN is defined.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset, state returns to 1
//   i_load    : load i_seed (a zero seed is replaced by 1)
//   i_advance : step the register once (ignored while i_load is high)
//   i_seed    : seed value
//   o_state   : current LFSR state
// ---------------------------------------------------------------------------
module idct_pgen_lfsr
    import idct_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [DATA_W-1:0] i_seed,
    output logic [DATA_W-1:0] o_state
);

    localparam logic [31:0]       TAPS_ALL = lfsrTaps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS     = TAPS_ALL[DATA_W-1:0];

    logic [DATA_W-1:0] r_state;
    logic [DATA_W-1:0] w_seedSafe;
    logic              w_feedback;

    // The all-zero state is the lock-up state of an XOR LFSR, so a zero
    // seed is promoted to 1.
    assign w_seedSafe = (i_seed == '0) ? DATA_W'(1) : i_seed;
    assign w_feedback = ^(r_state & TAPS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DATA_W'(1);
        end else if (i_load) begin
            r_state <= w_seedSafe;
        end else if (i_advance) begin
            r_state <= {r_state[DATA_W-2:0], w_feedback};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/idct_pattern_gen.sv
// ---------------------------------------------------------------------------
// idct_pattern_gen
//
// Block-structured test-pattern source for an IDCT datapath. A run of
// num_blks blocks of BLK_LEN samples is emitted over a valid/ready stream,
// with out_last marking the final sample of every block.
//
// Configuration macro: IDCT_PGEN_LFSR_EN
//   defined   : mode 10 produces a maximal-length LFSR sequence
//   undefined : no LFSR hardware, mode 10 behaves as ramp
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : one-cycle run request, honoured in IDLE only
//   abort      : drop the current run, back to IDLE, no done pulse
//   mode       : 00 ramp, 01 constant, 10 LFSR, 11 impulse
//   seed       : ramp base / constant / LFSR seed / impulse amplitude
//   num_blks   : blocks per run (0 means 1)
//   out_data   : sample
//   out_valid  : sample valid
//   out_ready  : consumer accept
//   out_last   : final sample of a block
//   busy       : high outside IDLE
//   done       : one-cycle pulse after the final transfer of a run
// ---------------------------------------------------------------------------
module idct_pattern_gen
    import idct_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BLK_LEN = 64,
    parameter int BLKS_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [BLKS_W-1:0] num_blks,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int             IDX_W    = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

    pgen_state_e       r_state;
    pgen_mode_e        r_mode;
    logic [DATA_W-1:0] r_seed;
    logic [BLKS_W-1:0] r_lastBlk;
    logic [IDX_W-1:0]  r_idx;
    logic [BLKS_W-1:0] r_blkCnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_done;

    pgen_mode_e        w_startMode;
    logic              w_start;
    logic              w_xfer;
    logic [IDX_W-1:0]  w_idxNext;
    logic              w_idxWrap;
    logic              w_lastBlk;

    // Sample value for the non-LFSR patterns at a given index within a block.
    function automatic logic [DATA_W-1:0] patternSample(
        input pgen_mode_e        m,
        input logic [DATA_W-1:0] s,
        input logic [IDX_W-1:0]  i
    );
        case (m)
            MODE_CONST:   return s;
            MODE_IMPULSE: return (i == '0) ? s : '0;
            default:      return s + DATA_W'(i);
        endcase
    endfunction

    // Mode as it will be latched at start. Without LFSR hardware, mode 10 is
    // folded onto ramp here so nothing downstream ever sees MODE_LFSR.
    always_comb begin
        w_startMode = pgen_mode_e'(mode);
`ifndef IDCT_PGEN_LFSR_EN
        if (mode == MODE_LFSR) begin
            w_startMode = MODE_RAMP;
        end
`endif
    end

    assign w_start   = (r_state == ST_IDLE) && start && !abort;
    assign w_xfer    = r_valid && out_ready;
    assign w_idxWrap = (r_idx == LAST_IDX);
    assign w_idxNext = w_idxWrap ? '0 : r_idx + 1'b1;
    assign w_lastBlk = (r_blkCnt == r_lastBlk);

    // Control FSM with registered stream outputs. Reset beats abort, abort
    // beats start and transfer. r_lastBlk holds num_blks-1 so the final block
    // is detected with a plain equality, and a requested 0 maps to 1 block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_RAMP;
            r_seed    <= '0;
            r_lastBlk <= '0;
            r_idx     <= '0;
            r_blkCnt  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else if (abort) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mode    <= w_startMode;
                        r_seed    <= seed;
                        r_lastBlk <= (num_blks == '0) ? '0 : num_blks - 1'b1;
                        r_idx     <= '0;
                        r_blkCnt  <= '0;
                        r_data    <= patternSample(w_startMode, seed, '0);
                        r_valid   <= 1'b1;
                        r_last    <= (LAST_IDX == '0);
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        if (w_idxWrap && w_lastBlk) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx  <= w_idxNext;
                            r_data <= patternSample(r_mode, r_seed, w_idxNext);
                            r_last <= (w_idxNext == LAST_IDX);
                            if (w_idxWrap) begin
                                r_blkCnt <= r_blkCnt + 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IDCT_PGEN_LFSR_EN
    logic [DATA_W-1:0] w_lfsrState;
    logic              w_lfsrLoad;
    logic              w_lfsrAdvance;

    // The LFSR is loaded at start and stepped on every accepted sample;
    // it is never reloaded at block boundaries.
    assign w_lfsrLoad    = w_start && (w_startMode == MODE_LFSR);
    assign w_lfsrAdvance = (r_state == ST_RUN) && w_xfer && !abort &&
                           (r_mode == MODE_LFSR);

    idct_pgen_lfsr #(
        .DATA_W    (DATA_W)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_lfsrLoad),
        .i_advance (w_lfsrAdvance),
        .i_seed    (seed),
        .o_state   (w_lfsrState)
    );

    // In LFSR mode the register itself is the sample; it only changes on a
    // transfer, so it holds under backpressure like r_data does.
    assign out_data = ((r_mode == MODE_LFSR) && (r_state == ST_RUN)) ?
                      w_lfsrState : r_data;
`else
    assign out_data = r_data;
`endif

    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_idct_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_idct_pattern_gen
//
// Directed bench for idct_pattern_gen with default parameters. Each run
// pushes its expected samples onto a scoreboard queue when the start is
// driven; samples are popped and compared as the DUT transfers them.
// Inputs change on the falling edge, outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_idct_pattern_gen;

    localparam int DATA_W  = 16;
    localparam int BLK_LEN = 64;
    localparam int BLKS_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    logic [BLKS_W-1:0] num_blks;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    idct_pattern_gen #(
        .DATA_W    (DATA_W),
        .BLK_LEN   (BLK_LEN),
        .BLKS_W    (BLKS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .seed      (seed),
        .num_blks  (num_blks),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // 100 MHz-style clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the DUT never finishes a run
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: pushes up to 'limit' expected samples of a run.
    // The LFSR is written out with explicit taps 16,15,13,4.
    function automatic void pushRun(input logic [1:0] m, input logic [15:0] s,
                                    input logic [7:0] nb, input int limit);
        int          nblk;
        int          pushed;
        logic [15:0] lfsr;
        logic [15:0] d;
        logic        fb;
        exp_t        e;
        nblk   = (nb == 8'd0) ? 1 : int'(nb);
        lfsr   = (s == 16'd0) ? 16'd1 : s;
        pushed = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < BLK_LEN; i++) begin
                if (pushed < limit) begin
                    case (m)
                        2'b01:   d = s;
`ifdef IDCT_PGEN_LFSR_EN
                        2'b10:   d = lfsr;
`endif
                        2'b11:   d = (i == 0) ? s : 16'd0;
                        default: d = 16'(s + 16'(i));
                    endcase
                    e.data = d;
                    e.last = (i == BLK_LEN - 1);
                    expQ.push_back(e);
                    pushed++;
                end
                fb   = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
                lfsr = {lfsr[14:0], fb};
            end
        end
    endfunction

    // Drive a start request on the current falling edge and queue the
    // expected samples of that run
    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] s,
                                 input logic [7:0] nb, input int limit);
        mode     = m;
        seed     = s;
        num_blks = nb;
        start    = 1'b1;
        abort    = 1'b0;
        pushRun(m, s, nb, limit);
    endtask

    // Consume queued samples. readyMode 0 keeps out_ready high, 1 toggles it
    // starting low. mode/seed/num_blks/start are scrambled during the run to
    // show they are ignored. With expectDone the done pulse is checked too.
    task automatic runAndCheck(input int readyMode, input bit expectDone,
                               input int maxCycles);
        int   cyc;
        bit   tog;
        exp_t e;
        cyc = 0;
        tog = 1'b0;
        while (expQ.size() > 0 && cyc < maxCycles) begin
            @(negedge clk);
            cyc++;
            start     = 1'($urandom_range(0, 1));
            mode      = 2'($urandom);
            seed      = 16'($urandom);
            num_blks  = 8'($urandom);
            out_ready = (readyMode == 0) ? 1'b1 : tog;
            tog       = ~tog;
            checkOutput("valid", 32'(out_valid), 32'd1);
            checkOutput("busy", 32'(busy), 32'd1);
            if (out_ready) begin
                e = expQ.pop_front();
                checkOutput("data", 32'(out_data), 32'(e.data));
                checkOutput("last", 32'(out_last), 32'(e.last));
            end else begin
                checkOutput("stallData", 32'(out_data), 32'(expQ[0].data));
                checkOutput("stallLast", 32'(out_last), 32'(expQ[0].last));
            end
        end
        if (expQ.size() > 0) begin
            checkOutput("timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        if (expectDone) begin
            @(negedge clk);
            start     = 1'b0;
            out_ready = 1'b1;
            checkOutput("donePulse", 32'(done), 32'd1);
            checkOutput("doneValid", 32'(out_valid), 32'd0);
            checkOutput("doneLast", 32'(out_last), 32'd0);
            checkOutput("doneBusy", 32'(busy), 32'd1);
            @(negedge clk);
            checkOutput("doneOnce", 32'(done), 32'd0);
            checkOutput("idleBusy", 32'(busy), 32'd0);
            checkOutput("idleValid", 32'(out_valid), 32'd0);
        end
    endtask

    // Directed sequence
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 2'b00;
        seed      = '0;
        num_blks  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstData", 32'(out_data), 32'd0);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstLast", 32'(out_last), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idleAfterRst", 32'(busy), 32'd0);

        // Ramp, seed 0, two blocks, no backpressure
        $display("[TB] ramp test");
        applyStimulus(2'b00, 16'h0000, 8'd2, 1 << 30);
        runAndCheck(0, 1'b1, 400);

        // Ramp wrapping through 0 with out_ready toggling
        $display("[TB] backpressure test");
        applyStimulus(2'b00, 16'hFFFE, 8'd1, 1 << 30);
        runAndCheck(1, 1'b1, 400);

        // Impulse over three blocks
        $display("[TB] impulse test");
        applyStimulus(2'b11, 16'h0100, 8'd3, 1 << 30);
        runAndCheck(0, 1'b1, 600);

        // Constant with num_blks=0, which must run exactly one block
        $display("[TB] constant test");
        applyStimulus(2'b01, 16'h1234, 8'd0, 1 << 30);
        runAndCheck(0, 1'b1, 400);

        // Mode 10: LFSR with zero seed, or ramp when the LFSR is built out
`ifdef IDCT_PGEN_LFSR_EN
        $display("[TB] lfsr test");
        applyStimulus(2'b10, 16'h0000, 8'd16, 1 << 30);
        runAndCheck(0, 1'b1, 2000);
`else
        $display("[TB] mode 10 as ramp test");
        applyStimulus(2'b10, 16'h0005, 8'd1, 1 << 30);
        runAndCheck(0, 1'b1, 400);
`endif

        // Abort at sample 10, with start raised alongside to test priority
        $display("[TB] abort test");
        applyStimulus(2'b00, 16'h0020, 8'd2, 10);
        runAndCheck(0, 1'b0, 100);
        @(negedge clk);
        checkOutput("abortSample10", 32'(out_data), 32'h002A);
        checkOutput("abortValidPre", 32'(out_valid), 32'd1);
        abort     = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("abortValid", 32'(out_valid), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortLast", 32'(out_last), 32'd0);
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("abortNoDone", 32'(done), 32'd0);
        checkOutput("abortStaysIdle", 32'(busy), 32'd0);
        applyStimulus(2'b00, 16'h0020, 8'd1, 1 << 30);
        runAndCheck(0, 1'b1, 400);

        // Reset mid-run with start held high during reset
        $display("[TB] reset test");
        applyStimulus(2'b00, 16'h0040, 8'd2, 5);
        runAndCheck(0, 1'b0, 100);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("midRstData", 32'(out_data), 32'd0);
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstLast", 32'(out_last), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        checkOutput("postRstValid", 32'(out_valid), 32'd0);
        checkOutput("postRstDone", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
